// File: rtl/tile_judge_pkg.sv
// Shared game definitions: FSM state encoding, bottom-row lane codes and
// the key-to-lane mapping used by the judge.
package tile_judge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam logic [2:0] EMPTY = 3'd0;
    localparam logic [2:0] LANE1 = 3'd1;
    localparam logic [2:0] LANE2 = 3'd2;
    localparam logic [2:0] LANE3 = 3'd3;
    localparam logic [2:0] LANE4 = 3'd4;

    // One-hot key vector to lane code; anything not exactly one-hot maps to
    // EMPTY, which never matches an occupied bottom row.
    function automatic logic [2:0] key_to_lane(input logic [3:0] k);
        logic [2:0] lane;
        case (k)
            4'b0001: lane = LANE1;
            4'b0010: lane = LANE2;
            4'b0100: lane = LANE3;
            4'b1000: lane = LANE4;
            default: lane = EMPTY;
        endcase
        return lane;
    endfunction

endpackage

// File: rtl/tile_judge_if.sv
// Player/shift-register facing signals of the tile judge.
interface tile_judge_if #(
    parameter int SCORE_W = 10
);
    logic               start;
    logic [3:0]         key;
    logic [2:0]         bottom_line;
    logic               shift;
    logic               correct_out;
    logic               game_over;
    logic [1:0]         state;
    logic [SCORE_W-1:0] score;

    modport master (
        output start, key, bottom_line,
        input  shift, correct_out, game_over, state, score
    );

    modport slave (
        input  start, key, bottom_line,
        output shift, correct_out, game_over, state, score
    );
endinterface

// File: rtl/tile_judge_pacer.sv
// Shift pacing: period register, tick counter and speed-up with a floor.
// A speed-up is staged in period_nxt and only becomes the live period when
// the current interval wraps, so a running count is never cut short.
module tile_pacer #(
    parameter int PERIOD_INIT = 25000000,
    parameter int PERIOD_MIN  = 6250000,
    parameter int PERIOD_STEP = 1250000,
    parameter int CNT_W       = $clog2(PERIOD_INIT + 1)
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic run,
    input  logic hold,
    input  logic speedup,
    output logic tick_done
);
    localparam logic [CNT_W-1:0] P_INIT = CNT_W'(PERIOD_INIT);
    localparam logic [CNT_W-1:0] P_MIN  = CNT_W'(PERIOD_MIN);
    localparam logic [CNT_W-1:0] P_STEP = CNT_W'(PERIOD_STEP);
    // One extra bit so min+step cannot wrap in the comparison.
    localparam logic [CNT_W:0]   P_THR  = (CNT_W+1)'(PERIOD_MIN + PERIOD_STEP);

    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] period_nxt;
    logic [CNT_W-1:0] cnt;

    assign tick_done = run && (cnt == period - 1'b1);

    // Counter advance, hold-at-terminal on hit, and staged period update.
    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            period     <= P_INIT;
            period_nxt <= P_INIT;
            cnt        <= '0;
        end else begin
            if (speedup)
                period_nxt <= ({1'b0, period_nxt} >= P_THR) ? (period_nxt - P_STEP) : P_MIN;
            if (run) begin
                if (!tick_done) begin
                    cnt <= cnt + 1'b1;
                end else if (!hold) begin
                    cnt    <= '0;
                    period <= period_nxt;
                end
            end
        end
    end
endmodule

// File: rtl/tile_judge.sv
// Gameplay controller in front of the tile shift register: paces shifts,
// judges key presses against the bottom row, keeps score and game state.
module tile_judge
    import tile_judge_pkg::*;
#(
    parameter int PERIOD_INIT   = 25000000,
    parameter int PERIOD_MIN    = 6250000,
    parameter int PERIOD_STEP   = 1250000,
    parameter int SPEEDUP_EVERY = 8,
    parameter int SCORE_W       = 10
) (
    input  logic        clk,
    input  logic        resetn,
    tile_judge_if.slave bus
);
    localparam int CNT_W = $clog2(PERIOD_INIT + 1);
    localparam int HIT_W = $clog2(SPEEDUP_EVERY + 1);

    state_t             state_q, state_n;
    logic [3:0]         key_prev;
    logic [3:0]         rise;
    logic [2:0]         rise_lane;
    logic [2:0]         bottom_eff;
    logic               tick_done;
    logic               hit;
    logic               hit_wrap;
    logic               shift_n, correct_n;
    logic               shift_q, correct_q;
    logic [SCORE_W-1:0] score_q;
    logic [HIT_W-1:0]   hit_cnt;

    assign rise      = bus.key & ~key_prev;
    assign rise_lane = key_to_lane(rise);
    // While correct_out is high the downstream row is being cleared at this
    // edge, so the still-visible tile must not be judged a second time.
    assign bottom_eff = correct_q ? EMPTY : bus.bottom_line;
    assign hit_wrap   = hit && (hit_cnt == HIT_W'(SPEEDUP_EVERY - 1));

    tile_pacer #(
        .PERIOD_INIT (PERIOD_INIT),
        .PERIOD_MIN  (PERIOD_MIN),
        .PERIOD_STEP (PERIOD_STEP),
        .CNT_W       (CNT_W)
    ) u_pacer (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (state_q != PLAY),
        .run       (state_q == PLAY),
        .hold      (hit),
        .speedup   (hit_wrap),
        .tick_done (tick_done)
    );

    // Game state register.
    always_ff @(posedge clk) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_n;
    end

    // Judge: next state plus the shift/correct decisions for the next cycle.
    always_comb begin
        state_n   = state_q;
        shift_n   = 1'b0;
        correct_n = 1'b0;
        hit       = 1'b0;
        case (state_q)
            IDLE: if (bus.start) state_n = PLAY;
            PLAY: begin
                if (bottom_eff == EMPTY) begin
                    if (tick_done) shift_n = 1'b1;
                end else if (rise != 4'b0000) begin
                    if (rise_lane == bottom_eff) begin
                        hit       = 1'b1;
                        correct_n = 1'b1;
                    end else begin
                        state_n = OVER;
                    end
                end else if (tick_done) begin
                    state_n = OVER;
                end
            end
            OVER: if (bus.start) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Key history and registered strobes.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            key_prev  <= 4'b0000;
            shift_q   <= 1'b0;
            correct_q <= 1'b0;
        end else begin
            key_prev  <= bus.key;
            shift_q   <= shift_n;
            correct_q <= correct_n;
        end
    end

    // Score and hit counter; cleared whenever the game is (re)entering IDLE.
    always_ff @(posedge clk) begin
        if (!resetn || state_n == IDLE) begin
            score_q <= '0;
            hit_cnt <= '0;
        end else if (hit) begin
            if (score_q != '1) score_q <= score_q + 1'b1;
            hit_cnt <= hit_wrap ? '0 : hit_cnt + 1'b1;
        end
    end

    assign bus.shift       = shift_q;
    assign bus.correct_out = correct_q;
    assign bus.game_over   = (state_q == OVER);
    assign bus.state       = state_q;
    assign bus.score       = score_q;
endmodule

// File: tb/tb_tile_judge.sv
// Directed bench for tile_judge with a short period so pacing is visible.
module tb_tile_judge;
    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    tile_judge_if #(.SCORE_W(10)) bus ();

    tile_judge #(
        .PERIOD_INIT   (8),
        .PERIOD_MIN    (4),
        .PERIOD_STEP   (2),
        .SPEEDUP_EVERY (2),
        .SCORE_W       (10)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        logic       st;
        logic [3:0] k;
        logic [2:0] b;
        logic       sh;
        logic       co;
        int         s;
        int         sc;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic st, input logic [3:0] k, input logic [2:0] b);
        @(negedge clk);
        bus.start       = st;
        bus.key         = k;
        bus.bottom_line = b;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic st, input logic [3:0] k, input logic [2:0] b,
                       input logic sh, input logic co, input int s, input int sc);
        vec_t v;
        v.st = st; v.k = k; v.b = b; v.sh = sh; v.co = co; v.s = s; v.sc = sc;
        tbl.push_back(v);
    endtask

    task automatic do_hit(input logic [2:0] lane);
        logic [3:0] k;
        k = 4'b0001 << (lane - 3'd1);
        step(1'b0, k, lane);
        chk("hit_pulse", int'(bus.correct_out), 1);
        chk("hit_no_shift", int'(bus.shift), 0);
        step(1'b0, 4'b0000, lane);
        chk("hit_single", int'(bus.correct_out), 0);
    endtask

    // Cycles between two consecutive shift pulses; -1 if none within budget.
    task automatic measure_gap(output int gap);
        int  n;
        bit  seen;
        n = 0; seen = 0; gap = -1;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 4'b0000, 3'd0);
            if (seen) n++;
            if (bus.shift) begin
                if (seen) begin
                    gap = n;
                    return;
                end
                seen = 1;
                n = 0;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        int got;

        bus.start = 1'b0; bus.key = 4'b0000; bus.bottom_line = 3'd0;
        resetn = 1'b0;
        step(1'b0, 4'b0000, 3'd0);
        step(1'b0, 4'b0000, 3'd0);
        chk("rst_state", int'(bus.state), 0);
        chk("rst_shift", int'(bus.shift), 0);
        chk("rst_correct", int'(bus.correct_out), 0);
        chk("rst_over", int'(bus.game_over), 0);
        chk("rst_score", int'(bus.score), 0);
        resetn = 1'b1;

        for (int i = 0; i < 20; i++) begin
            step(1'b0, 4'b0000, 3'd0);
            chk("idle_shift", int'(bus.shift), 0);
            chk("idle_state", int'(bus.state), 0);
        end

        // start, pacing at period 8, start ignored in PLAY, rise on empty
        // row ignored, lane-3 hit and a held key that must not re-trigger
        add(1, 4'h0, 0, 0, 0, 1, 0);
        add(0, 4'h0, 0, 0, 0, 1, 0);
        add(0, 4'h0, 0, 0, 0, 1, 0);
        add(0, 4'h0, 0, 0, 0, 1, 0);
        add(0, 4'h0, 0, 0, 0, 1, 0);
        add(1, 4'h0, 0, 0, 0, 1, 0);
        add(0, 4'h0, 0, 0, 0, 1, 0);
        add(0, 4'h0, 0, 0, 0, 1, 0);
        add(0, 4'h0, 0, 1, 0, 1, 0);
        add(0, 4'h0, 0, 0, 0, 1, 0);
        add(0, 4'h1, 0, 0, 0, 1, 0);
        for (int i = 11; i <= 15; i++) add(0, 4'h0, 0, 0, 0, 1, 0);
        add(0, 4'h0, 0, 1, 0, 1, 0);
        add(0, 4'h4, 3, 0, 1, 1, 1);
        add(0, 4'h4, 3, 0, 0, 1, 1);
        for (int i = 19; i <= 23; i++) add(0, 4'h4, 0, 0, 0, 1, 1);
        add(0, 4'h4, 0, 1, 0, 1, 1);
        add(0, 4'h4, 0, 0, 0, 1, 1);
        add(0, 4'h4, 0, 0, 0, 1, 1);
        add(0, 4'h0, 0, 0, 0, 1, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].st, tbl[i].k, tbl[i].b);
            chk($sformatf("tbl%0d_shift", i), int'(bus.shift), int'(tbl[i].sh));
            chk($sformatf("tbl%0d_correct", i), int'(bus.correct_out), int'(tbl[i].co));
            chk($sformatf("tbl%0d_state", i), int'(bus.state), tbl[i].s);
            chk($sformatf("tbl%0d_score", i), int'(bus.score), tbl[i].sc);
        end

        // speed-up: 8 -> 6 -> 4 -> floor 4
        do_hit(3'd1);
        measure_gap(gap);
        chk("gap_after_2_hits", gap, 6);
        chk("score_2", int'(bus.score), 2);
        do_hit(3'd2);
        do_hit(3'd4);
        measure_gap(gap);
        chk("gap_after_4_hits", gap, 4);
        chk("score_4", int'(bus.score), 4);
        do_hit(3'd3);
        do_hit(3'd1);
        measure_gap(gap);
        chk("gap_floor", gap, 4);
        chk("score_6", int'(bus.score), 6);

        // hit on the exact tick cycle: correct first, shift one cycle later
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'b0000, 3'd0);
            chk("pre_tick_shift", int'(bus.shift), 0);
        end
        step(1'b0, 4'b0001, 3'd1);
        chk("tickhit_correct", int'(bus.correct_out), 1);
        chk("tickhit_no_shift", int'(bus.shift), 0);
        step(1'b0, 4'b0000, 3'd1);
        chk("tickhit_shift_late", int'(bus.shift), 1);
        chk("tickhit_correct_off", int'(bus.correct_out), 0);
        step(1'b0, 4'b0000, 3'd0);
        chk("tickhit_shift_single", int'(bus.shift), 0);
        chk("score_7", int'(bus.score), 7);

        // reset mid-PLAY while a hit is being presented
        resetn = 1'b0;
        step(1'b0, 4'b0010, 3'd2);
        chk("midrst_state", int'(bus.state), 0);
        chk("midrst_score", int'(bus.score), 0);
        chk("midrst_correct", int'(bus.correct_out), 0);
        chk("midrst_shift", int'(bus.shift), 0);
        chk("midrst_over", int'(bus.game_over), 0);
        resetn = 1'b1;
        step(1'b0, 4'b0000, 3'd0);
        chk("postrst_idle", int'(bus.state), 0);

        // wrong-lane key -> OVER, score frozen, outputs quiet
        step(1'b1, 4'b0000, 3'd0);
        chk("miss_play", int'(bus.state), 1);
        do_hit(3'd3);
        step(1'b0, 4'b0001, 3'd2);
        chk("miss_state", int'(bus.state), 2);
        chk("miss_over", int'(bus.game_over), 1);
        chk("miss_correct", int'(bus.correct_out), 0);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, (i % 2 == 0) ? 4'b0010 : 4'b0000, (i % 2 == 0) ? 3'd2 : 3'd0);
            chk("over_shift", int'(bus.shift), 0);
            chk("over_correct", int'(bus.correct_out), 0);
        end
        chk("over_score_frozen", int'(bus.score), 1);
        chk("over_state", int'(bus.state), 2);
        step(1'b1, 4'b0000, 3'd0);
        chk("restart_idle", int'(bus.state), 0);
        chk("restart_score", int'(bus.score), 0);
        chk("restart_over_low", int'(bus.game_over), 0);

        // two keys rising together -> OVER
        step(1'b1, 4'b0000, 3'd0);
        step(1'b0, 4'b0011, 3'd2);
        chk("multikey_state", int'(bus.state), 2);
        chk("multikey_correct", int'(bus.correct_out), 0);
        step(1'b1, 4'b0000, 3'd0);
        chk("multikey_idle", int'(bus.state), 0);

        // escaped tile after a speed-up; no shift on the fatal tick
        step(1'b1, 4'b0000, 3'd0);
        do_hit(3'd4);
        do_hit(3'd4);
        got = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 4'b0000, 3'd1);
            chk("escape_no_shift", int'(bus.shift), 0);
            if (bus.state == 2'd2) begin
                got = 1;
                break;
            end
        end
        chk("escape_over", got, 1);
        chk("escape_score", int'(bus.score), 2);
        step(1'b1, 4'b0000, 3'd0);
        chk("escape_idle", int'(bus.state), 0);
        chk("escape_score_clr", int'(bus.score), 0);

        // period restored to the initial value for a new game
        step(1'b1, 4'b0000, 3'd0);
        measure_gap(gap);
        chk("gap_restored", gap, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
